// File: rtl/uart_cmd_pkg.sv
// Shared encodings for the UART command responder: FSM states, command codes,
// response status codes and response lengths.
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CMD     = 4'd1,
        ST_ADDR    = 4'd2,
        ST_DATA    = 4'd3,
        ST_CHK     = 4'd4,
        ST_EXEC    = 4'd5,
        ST_RD_WAIT = 4'd6,
        ST_SEND    = 4'd7,
        ST_TXW     = 4'd8
    } state_t;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    localparam logic [7:0] STAT_OK      = 8'h00;
    localparam logic [7:0] STAT_BADCHK  = 8'h01;
    localparam logic [7:0] STAT_BADCMD  = 8'h02;
    localparam logic [7:0] STAT_TIMEOUT = 8'h03;

    localparam logic [1:0] RSP_LEN_SHORT = 2'd2;
    localparam logic [1:0] RSP_LEN_READ  = 2'd3;

    function automatic logic isRxState(input state_t s);
        return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/uart_cmd_responder.sv
// Parses SOF/CMD/ADDR/DATA/CHK frames from the UART receiver, performs one local-bus
// access and answers through the UART transmitter. Optional RX timeout: UART_CMD_TIMEOUT_EN.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int         ADDR_W         = 8,
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter logic [7:0] RSP_BYTE       = 8'h5A,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_error,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic [3:0]        dbgState
);

    // Handshakes: rx_valid/rx_error are single-cycle pulses that are only consumed in
    // CMD..CHK; tx_start is a single-cycle request issued only while tx_busy is low, and
    // tx_data stays put until the transmitter drops tx_busy after that byte.

    state_t            stateQ, stateD;
    logic [7:0]        cmdQ, dataQ, chkAccQ, statusQ, rspDataQ;
    logic [ADDR_W-1:0] addrQ;
    logic [1:0]        rspLenQ, byteIdxQ;
    logic              txwFirstQ;
    logic              rxTake;
    logic              timeoutHit;

    assign rxTake = rx_valid && !rx_error;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] toCntQ;

    always_ff @(posedge clk) begin
        if (!rst_n || !isRxState(stateQ) || rx_valid) begin
            toCntQ <= '0;
        end else begin
            toCntQ <= toCntQ + 1'b1;
        end
    end

    assign timeoutHit = isRxState(stateQ) && !rx_valid && !rx_error &&
                        (toCntQ == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeoutHit = 1'b0;
`endif

    always_comb begin
        stateD   = stateQ;
        tx_start = 1'b0;
        reg_we   = 1'b0;
        reg_re   = 1'b0;
        case (stateQ)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SOF_BYTE)) begin
                    stateD = ST_CMD;
                end
            end
            ST_CMD, ST_ADDR, ST_DATA, ST_CHK: begin
                if (rx_error) begin
                    stateD = ST_IDLE;
                end else if (rx_valid) begin
                    case (stateQ)
                        ST_CMD:  stateD = ST_ADDR;
                        ST_ADDR: stateD = ST_DATA;
                        ST_DATA: stateD = ST_CHK;
                        default: stateD = ST_EXEC;
                    endcase
                end else if (timeoutHit) begin
                    stateD = ST_SEND;
                end
            end
            ST_EXEC: begin
                stateD = ST_SEND;
                if (statusQ == STAT_OK) begin
                    // An OK status already implies the command is a write or a read.
                    if (cmdQ == CMD_WR) begin
                        reg_we = rst_n;
                    end else begin
                        reg_re = rst_n;
                        stateD = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                stateD = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_start = rst_n;
                    stateD   = ST_TXW;
                end
            end
            ST_TXW: begin
                // tx_busy lags tx_start by one cycle, so the first TXW cycle says nothing.
                if (!txwFirstQ && !tx_busy) begin
                    stateD = (byteIdxQ == rspLenQ - 2'd1) ? ST_IDLE : ST_SEND;
                end
            end
            default: begin
                stateD = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ    <= ST_IDLE;
            cmdQ      <= 8'h00;
            addrQ     <= '0;
            dataQ     <= 8'h00;
            chkAccQ   <= 8'h00;
            statusQ   <= 8'h00;
            rspDataQ  <= 8'h00;
            rspLenQ   <= 2'd0;
            byteIdxQ  <= 2'd0;
            txwFirstQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            case (stateQ)
                ST_IDLE: begin
                    chkAccQ  <= 8'h00;
                    byteIdxQ <= 2'd0;
                end
                ST_CMD: begin
                    if (rxTake) begin
                        cmdQ    <= rx_data;
                        chkAccQ <= rx_data;
                    end
                end
                ST_ADDR: begin
                    if (rxTake) begin
                        addrQ   <= rx_data[ADDR_W-1:0];
                        chkAccQ <= chkAccQ ^ rx_data;
                    end
                end
                ST_DATA: begin
                    // Every frame carries a DATA slot; reads and bad commands send 8'h00.
                    if (rxTake) begin
                        dataQ   <= rx_data;
                        chkAccQ <= chkAccQ ^ rx_data;
                    end
                end
                ST_CHK: begin
                    if (rxTake) begin
                        rspLenQ <= RSP_LEN_SHORT;
                        if (rx_data != chkAccQ) begin
                            statusQ <= STAT_BADCHK;
                        end else if ((cmdQ == CMD_WR) || (cmdQ == CMD_RD)) begin
                            statusQ <= STAT_OK;
                            if (cmdQ == CMD_RD) begin
                                rspLenQ <= RSP_LEN_READ;
                            end
                        end else begin
                            statusQ <= STAT_BADCMD;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    rspDataQ <= reg_rdata;
                end
                ST_SEND: begin
                    if (tx_start) begin
                        txwFirstQ <= 1'b1;
                    end
                end
                ST_TXW: begin
                    txwFirstQ <= 1'b0;
                    if (stateD == ST_SEND) begin
                        byteIdxQ <= byteIdxQ + 2'd1;
                    end
                end
                default: begin
                end
            endcase
            if (timeoutHit) begin
                statusQ <= STAT_TIMEOUT;
                rspLenQ <= RSP_LEN_SHORT;
            end
        end
    end

    always_comb begin
        tx_data = 8'h00;
        if (rst_n && ((stateQ == ST_SEND) || (stateQ == ST_TXW))) begin
            case (byteIdxQ)
                2'd0:    tx_data = RSP_BYTE;
                2'd1:    tx_data = statusQ;
                default: tx_data = rspDataQ;
            endcase
        end
    end

    assign reg_addr  = addrQ;
    assign reg_wdata = dataQ;
    assign busy      = rst_n && (stateQ != ST_IDLE);
    assign dbgState  = stateQ;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: directed frame table plus hand-written
// sequences for rx_error, transmitter back-pressure, RX timeout and reset mid-response.
module tb_uart_cmd_responder;

    localparam int TO_CYC = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'hEE;
    logic       busy;
    logic [3:0] dbgState;

    logic forceBusy = 1'b0;
    logic mockBusy = 1'b0;
    assign tx_busy = forceBusy | mockBusy;

    uart_cmd_responder #(
        .ADDR_W(8), .SOF_BYTE(8'hA5), .RSP_BYTE(8'h5A), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_error(rx_error), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy), .dbgState(dbgState)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int nChecks = 0;
    int nFail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int weCount, reCount, startCount, stabErr, dblStart, busyStartErr;
    int lastRxCyc, firstStartCyc, busyLeft;
    logic [7:0] lastAddr, lastWdata, heldTx, rdVal;
    logic reSeen = 1'b0, pendStart = 1'b0, prevStart = 1'b0;

    // transmitter and register-file models, sampled on the falling edge
    always @(negedge clk) begin
        if (pendStart) begin
            mockBusy = 1'b1;
            busyLeft = 4;
            pendStart = 1'b0;
        end else if (busyLeft > 0) begin
            busyLeft--;
            if (busyLeft == 0) mockBusy = 1'b0;
        end
        if (mockBusy && (tx_data !== heldTx)) stabErr++;
        if (tx_start) begin
            if (tx_busy) busyStartErr++;
            if (prevStart) dblStart++;
            got_q.push_back(tx_data);
            heldTx = tx_data;
            startCount++;
            if (startCount == 1) firstStartCyc = cyc;
            pendStart = 1'b1;
        end
        prevStart = tx_start;
        if (reg_we) begin
            weCount++;
            lastAddr = reg_addr;
            lastWdata = reg_wdata;
        end
        if (reg_re) begin
            reCount++;
            lastAddr = reg_addr;
        end
        reg_rdata = reSeen ? rdVal : 8'hEE;
        reSeen = reg_re;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic clearMon();
        got_q.delete();
        exp_q.delete();
        weCount = 0; reCount = 0; startCount = 0; stabErr = 0;
        dblStart = 0; busyStartErr = 0; firstStartCyc = 0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        lastRxCyc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic waitIdle(input string name, input int maxCyc);
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({name, "_idle"}, busy, 1'b0);
        repeat (6) @(negedge clk);
    endtask

    task automatic checkRsp(input string name);
        check({name, "_ntx"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            check({name, "_txbyte"}, g, e);
        end
        check({name, "_proto"}, dblStart + busyStartErr + stabErr, 0);
    endtask

    typedef struct {
        string      name;
        logic [63:0] frame;
        int         nb;
        logic [7:0] rd;
        int         we;
        int         re;
        logic [7:0] addr;
        logic [7:0] wd;
        int         nrsp;
        logic [23:0] rsp;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string nm, input logic [63:0] f, input int nb,
                          input logic [7:0] rd, input int we, input int re,
                          input logic [7:0] addr, input logic [7:0] wd,
                          input int nrsp, input logic [23:0] rsp, input int lat);
        vec_t v;
        v.name = nm; v.frame = f; v.nb = nb; v.rd = rd; v.we = we; v.re = re;
        v.addr = addr; v.wd = wd; v.nrsp = nrsp; v.rsp = rsp; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic runVec(input vec_t v);
        clearMon();
        rdVal = v.rd;
        for (int i = 0; i < v.nb; i++) sendByte(v.frame[63-8*i -: 8]);
        waitIdle(v.name, 400);
        check({v.name, "_we"}, weCount, v.we);
        check({v.name, "_re"}, reCount, v.re);
        if ((v.we + v.re) > 0) check({v.name, "_addr"}, lastAddr, v.addr);
        if (v.we > 0) check({v.name, "_wdata"}, lastWdata, v.wd);
        check({v.name, "_lat"}, (firstStartCyc - lastRxCyc) >= v.lat, 1'b1);
        for (int i = 0; i < v.nrsp; i++) exp_q.push_back(v.rsp[23-8*i -: 8]);
        checkRsp(v.name);
    endtask

    task automatic checkAllZero(input string name);
        check({name, "_tx_start"}, tx_start, 1'b0);
        check({name, "_tx_data"}, tx_data, 8'h00);
        check({name, "_reg_we"}, reg_we, 1'b0);
        check({name, "_reg_re"}, reg_re, 1'b0);
        check({name, "_reg_addr"}, reg_addr, 8'h00);
        check({name, "_reg_wdata"}, reg_wdata, 8'h00);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_state"}, dbgState, 4'd0);
    endtask

    initial begin
        //     name      frame bytes (left-aligned)    nb  rd     we re addr   wd    n  rsp          lat
        addVec("wr10",   64'hA5_01_10_3C_2D_00_00_00, 5, 8'h00, 1, 0, 8'h10, 8'h3C, 2, 24'h5A00_00, 2);
        addVec("rd10",   64'hA5_02_10_00_12_00_00_00, 5, 8'hC7, 0, 1, 8'h10, 8'h00, 3, 24'h5A00C7,  3);
        addVec("badchk", 64'hA5_01_10_3C_FF_00_00_00, 5, 8'h00, 0, 0, 8'h00, 8'h00, 2, 24'h5A01_00, 2);
        addVec("badcmd", 64'hA5_07_10_00_17_00_00_00, 5, 8'h00, 0, 0, 8'h00, 8'h00, 2, 24'h5A02_00, 2);
        addVec("lead",   64'h00_FF_A5_02_10_00_12_00, 7, 8'h5E, 0, 1, 8'h10, 8'h00, 3, 24'h5A005E,  3);
        addVec("wrFF",   64'hA5_01_FF_00_FE_00_00_00, 5, 8'h00, 1, 0, 8'hFF, 8'h00, 2, 24'h5A00_00, 2);
        addVec("rd00",   64'hA5_02_00_00_02_00_00_00, 5, 8'hFF, 0, 1, 8'h00, 8'h00, 3, 24'h5A00FF,  3);
        addVec("rdchk",  64'hA5_02_10_00_13_00_00_00, 5, 8'h77, 0, 0, 8'h00, 8'h00, 2, 24'h5A01_00, 2);
        addVec("cmd00",  64'hA5_00_33_00_33_00_00_00, 5, 8'h00, 0, 0, 8'h00, 8'h00, 2, 24'h5A02_00, 2);
        addVec("cmdA5",  64'hA5_A5_01_00_A4_00_00_00, 5, 8'h00, 0, 0, 8'h00, 8'h00, 2, 24'h5A02_00, 2);

        // reset state
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) runVec(vecs[i]);

        // rx_error mid-frame drops it silently
        clearMon();
        sendByte(8'hA5);
        sendByte(8'h01);
        check("rxerr_busy_mid", busy, 1'b1);
        @(negedge clk); rx_error = 1'b1;
        @(negedge clk); rx_error = 1'b0;
        repeat (20) @(negedge clk);
        check("rxerr_busy", busy, 1'b0);
        check("rxerr_ntx", startCount, 0);
        check("rxerr_we", weCount, 0);
        runVec(vecs[0]);

        // transmitter busy at response start, extra RX bytes ignored
        clearMon();
        forceBusy = 1'b1;
        sendByte(8'hA5); sendByte(8'h01); sendByte(8'h22); sendByte(8'h5A); sendByte(8'h79);
        sendByte(8'hA5); sendByte(8'h02); sendByte(8'h10); sendByte(8'h00); sendByte(8'h12);
        repeat (25) @(negedge clk);
        check("hold_nostart", startCount, 0);
        check("hold_busy", busy, 1'b1);
        check("hold_txdata", tx_data, 8'h5A);
        forceBusy = 1'b0;
        waitIdle("hold", 200);
        check("hold_we", weCount, 1);
        check("hold_re", reCount, 0);
        check("hold_addr", lastAddr, 8'h22);
        check("hold_wdata", lastWdata, 8'h5A);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h00);
        checkRsp("hold");

        // partial frame followed by silence
        clearMon();
        sendByte(8'hA5);
        sendByte(8'h01);
        repeat (150) @(negedge clk);
`ifdef UART_CMD_TIMEOUT_EN
        check("to_busy", busy, 1'b0);
        check("to_late", (firstStartCyc - lastRxCyc) >= TO_CYC, 1'b1);
        check("to_we", weCount, 0);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h03);
        checkRsp("to");
`else
        check("noto_ntx", startCount, 0);
        check("noto_busy", busy, 1'b1);
`endif
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("noto_rst_busy", busy, 1'b0);
        repeat (10) @(negedge clk);

        // reset in the middle of a read response
        clearMon();
        rdVal = 8'h3C;
        sendByte(8'hA5); sendByte(8'h02); sendByte(8'h10); sendByte(8'h00); sendByte(8'h12);
        for (int i = 0; i < 50; i++) begin
            if (startCount > 0) break;
            @(negedge clk);
        end
        check("midrst_started", startCount, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkAllZero("midrst");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_nomore", startCount, 1);
        check("midrst_busy", busy, 1'b0);
        runVec(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
